// File: rtl/mem_store_buffer_pkg.sv
// mem_pkg: shared widths, buffer entry and port-state types for the store buffer.
package mem_pkg;
  localparam int ADDR_W = 18;
  localparam int DATA_W = 32;
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              byte_op;
  } sb_entry_t;
  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_DRAIN} port_state_t;
endpackage

// File: rtl/mem_store_buffer_if.sv
// mem_store_buffer_if: CPU request side and memory_block side of the store buffer.
interface mem_store_buffer_if;
  import mem_pkg::*;
  logic              cpu_req_valid;
  logic              cpu_req_ready;
  logic              cpu_write;
  logic              cpu_byte;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;
  logic              port_busy;
  logic              byteOperations;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] write_data;
  logic              memRead;
  logic              memWrite;
  logic [DATA_W-1:0] read_data;
  logic              empty;
  modport slave (
    input  cpu_req_valid, cpu_write, cpu_byte, cpu_addr, cpu_wdata, port_busy, read_data,
    output cpu_req_ready, cpu_rvalid, cpu_rdata, byteOperations, address, write_data,
           memRead, memWrite, empty
  );
  modport master (
    output cpu_req_valid, cpu_write, cpu_byte, cpu_addr, cpu_wdata, port_busy, read_data,
    input  cpu_req_ready, cpu_rvalid, cpu_rdata, byteOperations, address, write_data,
           memRead, memWrite, empty
  );
endinterface

// File: rtl/mem_store_buffer_fifo.sv
// sb_fifo: circular store storage with head/tail/count and newest-entry load lookup.
module sb_fifo
  import mem_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  sb_entry_t                i_entry,
  input  logic [ADDR_W-1:0]        i_lk_addr,
  input  logic                     i_lk_byte,
  output sb_entry_t                o_head,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_hit,
  output logic                     o_conflict,
  output logic [DATA_W-1:0]        o_fwd_data
);
  localparam int PW = $clog2(DEPTH);
  sb_entry_t r_mem [DEPTH];
  logic [PW-1:0] r_head, r_tail, w_idx;
  logic [PW:0]   r_count;
  logic          w_found;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_tail  <= i_push ? r_tail + 1'b1 : r_tail;
      r_head  <= i_pop ? r_head + 1'b1 : r_head;
      r_count <= r_count + {{PW{1'b0}}, i_push} - {{PW{1'b0}}, i_pop};
    end
  end
  always_ff @(posedge clk)
    if (i_push && !reset) r_mem[r_tail] <= i_entry;
  // walk oldest to newest so the newest same-word entry has the final say
  always_comb begin
    w_found    = 1'b0;
    w_idx      = r_head;
    o_hit      = 1'b0;
    o_fwd_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_idx = r_head + PW'(k);
      if ((PW+1)'(k) < r_count && r_mem[w_idx].addr[ADDR_W-1:2] == i_lk_addr[ADDR_W-1:2]) begin
        w_found    = 1'b1;
        o_hit      = r_mem[w_idx].addr == i_lk_addr && r_mem[w_idx].byte_op == i_lk_byte;
        o_fwd_data = i_lk_byte ? {{(DATA_W-8){1'b0}}, r_mem[w_idx].data[7:0]} : r_mem[w_idx].data;
      end
    end
    o_conflict = w_found & ~o_hit;
  end
  assign o_head  = r_mem[r_head];
  assign o_count = r_count;
endmodule

// File: rtl/mem_store_buffer.sv
// mem_store_buffer: write-posting store buffer arbitrating loads and drains onto memory_block.
module mem_store_buffer
  import mem_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input logic              clk,
  input logic              reset,
  mem_store_buffer_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  sb_entry_t         w_head, w_entry;
  logic [PW:0]       w_count;
  logic              w_hit, w_conflict, w_store, w_load, w_ready, w_miss, w_push, w_pop;
  logic              r_hit_rv;
  logic [DATA_W-1:0] w_fwd, r_rdata;
  port_state_t       r_state, w_next;
  assign w_store = bus.cpu_req_valid & bus.cpu_write;
  assign w_load  = bus.cpu_req_valid & ~bus.cpu_write;
  assign w_ready = bus.cpu_write ? ~w_count[PW] : w_hit | (~w_conflict & ~bus.port_busy);
  assign w_miss  = w_load & ~w_hit & ~w_conflict & ~bus.port_busy;
  assign w_push  = w_store & ~w_count[PW];
  assign w_pop   = w_next == ST_DRAIN;
  assign w_entry = '{addr: bus.cpu_addr, data: bus.cpu_wdata, byte_op: bus.cpu_byte};
  sb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .i_push     (w_push),
    .i_pop      (w_pop),
    .i_entry    (w_entry),
    .i_lk_addr  (bus.cpu_addr),
    .i_lk_byte  (bus.cpu_byte),
    .o_head     (w_head),
    .o_count    (w_count),
    .o_hit      (w_hit),
    .o_conflict (w_conflict),
    .o_fwd_data (w_fwd)
  );
  always_ff @(posedge clk)
    r_state <= reset ? ST_IDLE : w_next;
  // reset masks the port decision so a pending drain never reaches memory
  always_comb
    w_next = reset ? ST_IDLE :
             w_miss ? ST_LOAD :
             (~bus.port_busy && w_count != '0) ? ST_DRAIN : ST_IDLE;
  always_comb begin
    bus.cpu_req_ready  = w_ready;
    bus.memRead        = w_next == ST_LOAD;
    bus.memWrite       = w_next == ST_DRAIN;
    bus.address        = w_next == ST_LOAD ? bus.cpu_addr : w_next == ST_DRAIN ? w_head.addr : '0;
    bus.write_data     = w_next == ST_DRAIN ? w_head.data : '0;
    bus.byteOperations = w_next == ST_LOAD ? bus.cpu_byte : w_next == ST_DRAIN & w_head.byte_op;
    bus.empty          = w_count == '0;
    bus.cpu_rvalid     = r_hit_rv | (r_state == ST_LOAD);
    bus.cpu_rdata      = r_rdata;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hit_rv <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_hit_rv <= w_load & w_hit;
      r_rdata  <= (w_load & w_hit) ? w_fwd : w_next == ST_LOAD ? bus.read_data : r_rdata;
    end
  end
endmodule

// File: tb/tb_mem_store_buffer.sv
// tb_mem_store_buffer: directed scenarios against a small memory_block model.
module tb_mem_store_buffer;
  logic clk, reset;
  int n_cmp = 0, n_fail = 0;
  logic [31:0] mem [256];
  logic [31:0] rd_word;
  logic [17:0] wr_log [$];
  int base;
  mem_store_buffer_if bus();
  mem_store_buffer #(.DEPTH(4)) dut (.clk(clk), .reset(reset), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  assign rd_word = (bus.address[9:2] == 8'h40) ? 32'hCAFEF00D : mem[bus.address[9:2]];
  assign bus.read_data = bus.byteOperations ? {24'b0, rd_word[8*bus.address[1:0] +: 8]} : rd_word;
  always @(posedge clk)
    if (bus.memWrite) begin
      wr_log.push_back(bus.address);
      if (bus.byteOperations) mem[bus.address[9:2]][8*bus.address[1:0] +: 8] <= bus.write_data[7:0];
      else mem[bus.address[9:2]] <= bus.write_data;
    end
  task automatic tick(); @(posedge clk); #1; endtask
  task automatic req(input logic v, input logic w, input logic b, input logic [17:0] a, input logic [31:0] d);
    bus.cpu_req_valid = v; bus.cpu_write = w; bus.cpu_byte = b; bus.cpu_addr = a; bus.cpu_wdata = d;
  endtask
  task automatic test_reset();
    reset = 1'b1; bus.port_busy = 1'b0; req(0, 0, 0, 0, 0);
    tick(); tick();
    @(negedge clk);
    n_cmp++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL rst_empty got %b want 1", bus.empty); end
    n_cmp++; if (bus.memWrite !== 1'b0 || bus.memRead !== 1'b0) begin n_fail++; $display("FAIL rst_port got rd=%b wr=%b want 0 0", bus.memRead, bus.memWrite); end
    n_cmp++; if (bus.address !== 18'h0 || bus.write_data !== 32'h0 || bus.byteOperations !== 1'b0) begin n_fail++; $display("FAIL rst_bus got a=%h d=%h b=%b want 0", bus.address, bus.write_data, bus.byteOperations); end
    n_cmp++; if (bus.cpu_rvalid !== 1'b0 || bus.cpu_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_rd got v=%b d=%h want 0 0", bus.cpu_rvalid, bus.cpu_rdata); end
    tick(); reset = 1'b0;
  endtask
  task automatic test_store_drain();
    req(1, 1, 0, 18'h10, 32'hDEADBEEF);
    @(negedge clk);
    n_cmp++; if (bus.cpu_req_ready !== 1'b1) begin n_fail++; $display("FAIL t1_ready got %b want 1", bus.cpu_req_ready); end
    tick(); req(0, 0, 0, 0, 0);
    @(negedge clk);
    n_cmp++; if (bus.memWrite !== 1'b1 || bus.address !== 18'h10) begin n_fail++; $display("FAIL t1_drain got wr=%b a=%h want 1 00010", bus.memWrite, bus.address); end
    n_cmp++; if (bus.write_data !== 32'hDEADBEEF || bus.byteOperations !== 1'b0) begin n_fail++; $display("FAIL t1_wdata got %h b=%b want deadbeef 0", bus.write_data, bus.byteOperations); end
    n_cmp++; if (bus.empty !== 1'b0) begin n_fail++; $display("FAIL t1_notempty got %b want 0", bus.empty); end
    tick();
    @(negedge clk);
    n_cmp++; if (bus.empty !== 1'b1 || bus.memWrite !== 1'b0) begin n_fail++; $display("FAIL t1_empty got e=%b wr=%b want 1 0", bus.empty, bus.memWrite); end
  endtask
  task automatic test_forward_word();
    tick(); bus.port_busy = 1'b1; req(1, 1, 0, 18'h20, 32'h12345678);
    tick(); req(1, 0, 0, 18'h20, 0);
    @(negedge clk);
    n_cmp++; if (bus.cpu_req_ready !== 1'b1 || bus.memRead !== 1'b0) begin n_fail++; $display("FAIL t2_hit got rdy=%b rd=%b want 1 0", bus.cpu_req_ready, bus.memRead); end
    tick(); req(0, 0, 0, 0, 0);
    @(negedge clk);
    n_cmp++; if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== 32'h12345678) begin n_fail++; $display("FAIL t2_fwd got v=%b d=%h want 1 12345678", bus.cpu_rvalid, bus.cpu_rdata); end
  endtask
  task automatic test_byte_conflict();
    tick(); req(1, 1, 1, 18'h21, 32'h555555AB);
    tick(); req(1, 0, 1, 18'h21, 0);
    @(negedge clk);
    n_cmp++; if (bus.cpu_req_ready !== 1'b1) begin n_fail++; $display("FAIL t3_bhit_rdy got %b want 1", bus.cpu_req_ready); end
    tick(); req(1, 0, 1, 18'h22, 0);
    @(negedge clk);
    n_cmp++; if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== 32'h000000AB) begin n_fail++; $display("FAIL t3_bfwd got v=%b d=%h want 1 000000ab", bus.cpu_rvalid, bus.cpu_rdata); end
    n_cmp++; if (bus.cpu_req_ready !== 1'b0) begin n_fail++; $display("FAIL t3_conf_rdy got %b want 0", bus.cpu_req_ready); end
    tick();
    @(negedge clk);
    n_cmp++; if (bus.cpu_req_ready !== 1'b0 || bus.cpu_rvalid !== 1'b0 || bus.memRead !== 1'b0) begin n_fail++; $display("FAIL t3_stall got rdy=%b v=%b rd=%b want 0 0 0", bus.cpu_req_ready, bus.cpu_rvalid, bus.memRead); end
    tick(); bus.port_busy = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.memWrite !== 1'b1 || bus.address !== 18'h20 || bus.cpu_req_ready !== 1'b0) begin n_fail++; $display("FAIL t3_dr0 got wr=%b a=%h rdy=%b want 1 00020 0", bus.memWrite, bus.address, bus.cpu_req_ready); end
    tick();
    @(negedge clk);
    n_cmp++; if (bus.memWrite !== 1'b1 || bus.address !== 18'h21 || bus.byteOperations !== 1'b1 || bus.cpu_req_ready !== 1'b0) begin n_fail++; $display("FAIL t3_dr1 got wr=%b a=%h b=%b rdy=%b want 1 00021 1 0", bus.memWrite, bus.address, bus.byteOperations, bus.cpu_req_ready); end
    tick();
    @(negedge clk);
    n_cmp++; if (bus.memRead !== 1'b1 || bus.memWrite !== 1'b0 || bus.address !== 18'h22 || bus.byteOperations !== 1'b1 || bus.cpu_req_ready !== 1'b1) begin n_fail++; $display("FAIL t3_miss got rd=%b wr=%b a=%h b=%b rdy=%b want 1 0 00022 1 1", bus.memRead, bus.memWrite, bus.address, bus.byteOperations, bus.cpu_req_ready); end
    tick(); req(0, 0, 0, 0, 0);
    @(negedge clk);
    n_cmp++; if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== 32'h00000034) begin n_fail++; $display("FAIL t3_mdata got v=%b d=%h want 1 00000034", bus.cpu_rvalid, bus.cpu_rdata); end
  endtask
  task automatic test_full();
    logic [17:0] exp_a [5] = '{18'h40, 18'h44, 18'h48, 18'h4C, 18'h50};
    tick(); bus.port_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin req(1, 1, 0, exp_a[i], 32'hA0 + i); tick(); end
    req(1, 1, 0, 18'h50, 32'h55);
    @(negedge clk);
    n_cmp++; if (bus.cpu_req_ready !== 1'b0 || bus.empty !== 1'b0) begin n_fail++; $display("FAIL t4_full got rdy=%b e=%b want 0 0", bus.cpu_req_ready, bus.empty); end
    tick(); base = wr_log.size(); bus.port_busy = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.cpu_req_ready !== 1'b0 || bus.memWrite !== 1'b1 || bus.address !== 18'h40) begin n_fail++; $display("FAIL t4_pop0 got rdy=%b wr=%b a=%h want 0 1 00040", bus.cpu_req_ready, bus.memWrite, bus.address); end
    tick();
    @(negedge clk);
    n_cmp++; if (bus.cpu_req_ready !== 1'b1) begin n_fail++; $display("FAIL t4_credit got %b want 1", bus.cpu_req_ready); end
    tick(); req(0, 0, 0, 0, 0);
    tick(); tick(); tick();
    @(negedge clk);
    n_cmp++; if (wr_log.size() - base !== 5) begin n_fail++; $display("FAIL t4_nwr got %0d want 5", wr_log.size() - base); end
    for (int i = 0; i < 5; i++)
      if (base + i < wr_log.size()) begin
        n_cmp++; if (wr_log[base+i] !== exp_a[i]) begin n_fail++; $display("FAIL t4_order%0d got %h want %h", i, wr_log[base+i], exp_a[i]); end
      end
    n_cmp++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL t4_empty got %b want 1", bus.empty); end
  endtask
  task automatic test_load_priority();
    tick(); bus.port_busy = 1'b1; req(1, 1, 0, 18'h200, 32'h11);
    tick(); req(1, 1, 0, 18'h204, 32'h22);
    tick(); bus.port_busy = 1'b0; req(1, 0, 0, 18'h100, 0);
    @(negedge clk);
    n_cmp++; if (bus.memRead !== 1'b1 || bus.memWrite !== 1'b0 || bus.address !== 18'h100 || bus.cpu_req_ready !== 1'b1) begin n_fail++; $display("FAIL t5_load got rd=%b wr=%b a=%h rdy=%b want 1 0 00100 1", bus.memRead, bus.memWrite, bus.address, bus.cpu_req_ready); end
    tick(); req(0, 0, 0, 0, 0);
    @(negedge clk);
    n_cmp++; if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== 32'hCAFEF00D) begin n_fail++; $display("FAIL t5_rdata got v=%b d=%h want 1 cafef00d", bus.cpu_rvalid, bus.cpu_rdata); end
    n_cmp++; if (bus.memWrite !== 1'b1 || bus.address !== 18'h200 || bus.write_data !== 32'h11) begin n_fail++; $display("FAIL t5_dr0 got wr=%b a=%h d=%h want 1 00200 11", bus.memWrite, bus.address, bus.write_data); end
    tick();
    @(negedge clk);
    n_cmp++; if (bus.memWrite !== 1'b1 || bus.address !== 18'h204 || bus.cpu_rvalid !== 1'b0) begin n_fail++; $display("FAIL t5_dr1 got wr=%b a=%h v=%b want 1 00204 0", bus.memWrite, bus.address, bus.cpu_rvalid); end
    tick();
  endtask
  task automatic test_reset_drain();
    bus.port_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin req(1, 1, 0, 18'h300 + 18'(4*i), 32'h70 + i); tick(); end
    req(0, 0, 0, 0, 0); bus.port_busy = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.memWrite !== 1'b1 || bus.address !== 18'h300) begin n_fail++; $display("FAIL t6_drain got wr=%b a=%h want 1 00300", bus.memWrite, bus.address); end
    reset = 1'b1; base = wr_log.size();
    tick();
    @(negedge clk);
    n_cmp++; if (bus.memWrite !== 1'b0 || bus.empty !== 1'b1 || bus.cpu_rvalid !== 1'b0) begin n_fail++; $display("FAIL t6_rst got wr=%b e=%b v=%b want 0 1 0", bus.memWrite, bus.empty, bus.cpu_rvalid); end
    tick(); reset = 1'b0;
    tick(); tick(); tick(); tick();
    @(negedge clk);
    n_cmp++; if (wr_log.size() !== base || bus.empty !== 1'b1) begin n_fail++; $display("FAIL t6_nowr got writes=%0d e=%b want 0 1", wr_log.size() - base, bus.empty); end
  endtask
  initial begin
    test_reset();
    test_store_drain();
    test_forward_word();
    test_byte_conflict();
    test_full();
    test_load_priority();
    test_reset_drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
